// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder:
// access-size codes, FSM state type and parameter defaults.
package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   localparam int DEF_DEPTH_WORDS = 256;
   localparam int DEF_WAIT_CYCLES = 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DONE
   } state_t;

endpackage

// File: rtl/dmem_lane_mux.sv
// Byte-lane steering: store byte enables / replicated write data,
// load extraction with sign or zero extension, and access rejection.
module dmem_lane_mux
   import dmem_pkg::*;
(
   input  logic        is_store,
   input  logic [1:0]  lane,
   input  logic [2:0]  funct3,
   input  logic [31:0] store_data,
   input  logic [31:0] word,
   output logic [3:0]  byte_en,
   output logic [31:0] write_data,
   output logic [31:0] load_data,
   output logic        bad
);

   logic [31:0] shifted;

   assign shifted = word >> {lane, 3'b000};

   always_comb begin
      byte_en    = 4'b0000;
      write_data = 32'h0;
      load_data  = 32'h0;
      bad        = 1'b0;
      case (funct3)
         F3_B: begin
            byte_en    = 4'b0001 << lane;
            write_data = {4{store_data[7:0]}};
            load_data  = {{24{shifted[7]}}, shifted[7:0]};
         end
         F3_H: begin
            bad        = lane[0];
            byte_en    = lane[1] ? 4'b1100 : 4'b0011;
            write_data = {2{store_data[15:0]}};
            load_data  = {{16{shifted[15]}}, shifted[15:0]};
         end
         F3_W: begin
            bad        = (lane != 2'b00);
            byte_en    = 4'b1111;
            write_data = store_data;
            load_data  = word;
         end
         F3_BU: begin
            bad       = is_store;
            load_data = {24'h0, shifted[7:0]};
         end
         F3_HU: begin
            bad       = is_store | lane[0];
            load_data = {16'h0, shifted[15:0]};
         end
         default: bad = 1'b1;
      endcase
      // a rejected access never touches storage and returns zero
      if (bad) begin
         byte_en   = 4'b0000;
         load_data = 32'h0;
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Wait-state data-memory responder: IDLE/WAIT/DONE handshake,
// byte-lane stores and extended loads into a word array.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
   parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
   input  logic        clock,
   input  logic        reset_,
   input  logic        memread,
   input  logic        memwrite,
   input  logic [31:0] aluOut,
   input  logic [31:0] readData2,
   input  logic [2:0]  funct3,
   output logic [31:0] readDataDMem,
   output logic        ready,
   output logic        err
);

   localparam int IW = $clog2(DEPTH_WORDS);
   localparam logic HAS_WAIT = (WAIT_CYCLES > 0);
   localparam logic [3:0] CNT_INIT =
      HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;

   state_t      state, state_n;
   logic [3:0]  cnt;
   logic [31:0] addr_q, data_q;
   logic [2:0]  f3_q;
   logic        store_q, err_q;

   logic [31:0] mem [DEPTH_WORDS];

   logic        req, idle, enter_done, commit;
   logic [31:0] a_addr, a_data;
   logic [2:0]  a_f3;
   logic        a_store;
   logic [IW-1:0] idx;
   logic [3:0]  byte_en;
   logic [31:0] write_data, load_data;
   logic        bad;

   assign req  = memread | memwrite;
   assign idle = (state == S_IDLE);

   // With no wait states the access completes on the capture edge,
   // so the live inputs must feed the datapath while idle.
   assign a_addr  = idle ? aluOut    : addr_q;
   assign a_data  = idle ? readData2 : data_q;
   assign a_f3    = idle ? funct3    : f3_q;
   assign a_store = idle ? memwrite  : store_q;
   assign idx     = a_addr[IW+1:2];

   dmem_lane_mux u_lane (
      .is_store   (a_store),
      .lane       (a_addr[1:0]),
      .funct3     (a_f3),
      .store_data (a_data),
      .word       (mem[idx]),
      .byte_en    (byte_en),
      .write_data (write_data),
      .load_data  (load_data),
      .bad        (bad)
   );

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE: if (req) state_n = HAS_WAIT ? S_WAIT : S_DONE;
         S_WAIT: if (cnt == 4'd0) state_n = S_DONE;
         S_DONE: state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   assign enter_done = (state_n == S_DONE) && (state != S_DONE);
   assign commit     = enter_done & a_store & ~bad & ~reset_;

   always_ff @(posedge clock or posedge reset_) begin
      if (reset_) begin
         state        <= S_IDLE;
         cnt          <= 4'd0;
         addr_q       <= 32'h0;
         data_q       <= 32'h0;
         f3_q         <= 3'd0;
         store_q      <= 1'b0;
         err_q        <= 1'b0;
         readDataDMem <= 32'h0;
      end else begin
         state <= state_n;
         if (idle && req) begin
            addr_q  <= aluOut;
            data_q  <= readData2;
            f3_q    <= funct3;
            store_q <= memwrite;
            cnt     <= CNT_INIT;
         end else if (state == S_WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end
         if (enter_done) begin
            err_q <= bad;
            if (bad)
               readDataDMem <= 32'h0;
            else if (!a_store)
               readDataDMem <= load_data;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (commit) begin
         for (int b = 0; b < 4; b++)
            if (byte_en[b])
               mem[idx][8*b +: 8] <= write_data[8*b +: 8];
      end
   end

   assign ready = (state == S_DONE);
   assign err   = ready & err_q;

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, is the number of 32-bit storage words (power of two, 4..4096).
REQ-002 Parameter WAIT_CYCLES, default 1, is the number of wait states inserted before an access completes (0..15).
REQ-003 clock  input  1  sole clock; all state changes on rising edge.
REQ-004 reset_  input  1  asynchronous, active-high reset.
REQ-005 memread  input  1  load request from core.
REQ-006 memwrite  input  1  store request from core.
REQ-007 aluOut  input  32  byte address of access.
REQ-008 readData2  input  32  store data, right-aligned.
REQ-009 funct3  input  3  access size/sign: 0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU.
REQ-010 readDataDMem  output  32  load result, right-aligned and extended.
REQ-011 ready  output  1  one-cycle pulse marking access completion.
REQ-012 err  output  1  one-cycle pulse with ready when the access was rejected.

Function
REQ-013 FSM states: IDLE, WAIT, DONE; reset state IDLE.
REQ-014 In IDLE, memread or memwrite high at a clock edge captures aluOut, readData2, funct3 and op; next state WAIT if WAIT_CYCLES>0, else DONE.
REQ-015 Both memread and memwrite high: captured as a store (store priority).
REQ-016 WAIT loads counter with WAIT_CYCLES-1 on entry, decrements each cycle, goes to DONE when counter is 0; total latency request-edge to ready = WAIT_CYCLES+1 cycles.
REQ-017 DONE asserts ready for exactly one cycle, then returns to IDLE; a request is sampled again only in IDLE (back-to-back requests need one IDLE cycle between).
REQ-018 Requests presented in WAIT or DONE are ignored, not queued.
REQ-019 Word index = captured address[31:2] modulo DEPTH_WORDS (silent wrap, no error).
REQ-020 Store commits on the edge entering DONE; SB writes lane address[1:0], SH writes lanes {address[1],0}+1..0, SW writes all four; other lanes unchanged.
REQ-021 Load: readDataDMem registered on the edge entering DONE, held until next completion; LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
REQ-022 Reject (err=1, no storage change, readDataDMem=0): halfword with address[0]=1; word with address[1:0]!=0; funct3 in {3,6,7}; store with funct3 4 or 5.
REQ-023 Read-after-write to same address in consecutive transactions returns the newly written data.

Reset
REQ-024 reset_ high forces state IDLE, counter 0, ready 0, err 0, readDataDMem 0 immediately, independent of clock.
REQ-025 Reset during WAIT aborts the transaction; a pending store is not committed.
REQ-026 Storage array is not reset; contents undefined until written.

Structure
REQ-027 Shared package dmem_pkg holds funct3 size constants, the FSM state type, and DEPTH_WORDS/WAIT_CYCLES defaults.
REQ-028 Sub-module dmem_lane_mux (combinational) produces store byte enables/aligned write data and load extraction/extension; the FSM, counter and array stay in dmem_responder.

Verification
REQ-029 WAIT_CYCLES=1: SW 0x10FEDE01 at 0x1B8, then LW 0x1B8 -> ready 2 cycles after each request edge, readDataDMem=0x10FEDE01, err=0.
REQ-030 After REQ-029 store: LB 0x1B8 -> 0x00000001; LH 0x1BA -> 0x000010FE; LBU 0x1BB -> 0x00000010; SB 0xFF at 0x1B9 then LW 0x1B8 -> 0x10FEFF01; LB 0x1B9 -> 0xFFFFFFFF.
REQ-031 LW 0x1B9, SH 0x1BB, funct3=3 -> each ready with err=1, readDataDMem=0, subsequent LW 0x1B8 unchanged.
REQ-032 DEPTH_WORDS=256: SW 0xA5A5A5A5 at 0x400 -> LW 0x000 returns 0xA5A5A5A5 (wrap).
REQ-033 SW 0x12345678 at 0x20 issued, reset_ pulsed during WAIT -> outputs 0 immediately, ready never pulses for that store, later LW 0x20 returns prior value; memread+memwrite together at 0x24 with 0xCAFEBABE -> LW 0x24 returns 0xCAFEBABE.
REQ-034 WAIT_CYCLES=0 and 3: request held high continuously -> ready pulses every 2 and every 5 cycles respectively; requests during WAIT/DONE produce no extra ready.
